// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } mdu_state_e;

    function automatic logic is_div(input mdu_op_e op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_a(input mdu_op_e op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(input mdu_op_e op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module mdu_div_step
    import mdu_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] div_i,
    input  logic            bit_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);

    logic [XLEN+1:0] shift_s;
    logic [XLEN:0]   trial_s;
    logic            ge_s;

    // Trial subtraction; the wrapped difference is only kept when it is non-negative.
    always_comb begin
        shift_s = {rem_i, bit_i};
        ge_s    = (shift_s >= {2'b00, div_i});
        trial_s = shift_s[XLEN:0] - {1'b0, div_i};
        if (ge_s) begin
            rem_o = trial_s;
            q_o   = 1'b1;
        end else begin
            rem_o = shift_s[XLEN:0];
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes on both sides.
// Define MDU_MUL_EN to build the multiply datapath; otherwise multiply ops return out_illegal.
module mdu_iterative
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_W  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      state_q, state_d;
    mdu_op_e         op_q, op_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [4:0]      rd_q, rd_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            vld_q, vld_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;

    mdu_op_e         op_in_s;
    logic            accept_s;
    logic            sa_in_s, sb_in_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s;
    logic            div_zero_s, div_ovf_s;
    logic [XLEN-1:0] spec_res_s;
    logic [XLEN:0]   rem_step_s;
    logic            q_bit_s;
    logic [XLEN-1:0] quo_next_s, quo_fix_s, rem_fix_s, final_res_s;

`ifdef MDU_MUL_EN
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_next_s, prod_fix_s;
`else
    logic              ill_q, ill_d;
`endif

    assign accept_s = in_valid && in_ready;

    mdu_div_step u_div_step (
        .rem_i (rem_q),
        .div_i (dvs_q),
        .bit_i (quo_q[XLEN-1]),
        .rem_o (rem_step_s),
        .q_o   (q_bit_s)
    );

    // Request decode: operand signs, magnitudes and the single-edge special cases.
    always_comb begin
        op_in_s    = mdu_op_e'(in_op);
        sa_in_s    = is_signed_a(op_in_s) & in_a[XLEN-1];
        sb_in_s    = is_signed_b(op_in_s) & in_b[XLEN-1];
        a_mag_s    = sa_in_s ? (~in_a + 32'd1) : in_a;
        b_mag_s    = sb_in_s ? (~in_b + 32'd1) : in_b;
        div_zero_s = is_div(op_in_s) && (in_b == ZERO_W);
        div_ovf_s  = ((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                     (in_a == MIN_W) && (in_b == ONES_W);
        case (op_in_s)
            OP_DIV, OP_DIVU: spec_res_s = div_zero_s ? ONES_W : MIN_W;
            OP_REM, OP_REMU: spec_res_s = div_zero_s ? in_a : ZERO_W;
            default:         spec_res_s = ZERO_W;
        endcase
    end

    // Final-iteration results with sign fix-up applied.
    always_comb begin
        quo_next_s = {quo_q[XLEN-2:0], q_bit_s};
        quo_fix_s  = (sa_q ^ sb_q) ? (~quo_next_s + 32'd1) : quo_next_s;
        rem_fix_s  = sa_q ? (~rem_step_s[XLEN-1:0] + 32'd1) : rem_step_s[XLEN-1:0];
`ifdef MDU_MUL_EN
        mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};
        prod_fix_s = (sa_q ^ sb_q) ? (~mul_next_s + 64'd1) : mul_next_s;
`endif
        case (op_q)
`ifdef MDU_MUL_EN
            OP_MUL:                        final_res_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res_s = prod_fix_s[2*XLEN-1:XLEN];
`endif
            OP_DIV, OP_DIVU:               final_res_s = quo_fix_s;
            OP_REM, OP_REMU:               final_res_s = rem_fix_s;
            default:                       final_res_s = ZERO_W;
        endcase
    end

    // Next-state logic for the IDLE/CALC/DONE sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        vld_d   = vld_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
`ifdef MDU_MUL_EN
        acc_d   = acc_q;
        mcand_d = mcand_q;
`else
        ill_d   = ill_q;
`endif
        if (flush) begin
            state_d = IDLE;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        op_d    = op_in_s;
                        rd_d    = in_rd;
                        sa_d    = sa_in_s;
                        sb_d    = sb_in_s;
                        cnt_d   = 5'd31;
                        rem_d   = 33'd0;
                        quo_d   = a_mag_s;
                        dvs_d   = b_mag_s;
`ifdef MDU_MUL_EN
                        acc_d   = {32'd0, b_mag_s};
                        mcand_d = a_mag_s;
                        if (div_zero_s || div_ovf_s) begin
`else
                        ill_d   = 1'b0;
                        if (!is_div(op_in_s)) begin
                            state_d = DONE;
                            vld_d   = 1'b1;
                            res_d   = ZERO_W;
                            ill_d   = 1'b1;
                        end else if (div_zero_s || div_ovf_s) begin
`endif
                            state_d = DONE;
                            vld_d   = 1'b1;
                            res_d   = spec_res_s;
                        end else begin
                            state_d = CALC;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    if (is_div(op_q)) begin
                        rem_d = rem_step_s;
                        quo_d = quo_next_s;
                    end else begin
`ifdef MDU_MUL_EN
                        acc_d = mul_next_s;
`else
                        quo_d = quo_q;
`endif
                    end
                    if (cnt_q == 5'd0) begin
                        state_d = DONE;
                        vld_d   = 1'b1;
                        res_d   = final_res_s;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= 5'd0;
            rd_q    <= 5'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            vld_q   <= 1'b0;
            rem_q   <= 33'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            res_q   <= 32'd0;
`ifdef MDU_MUL_EN
            acc_q   <= 64'd0;
            mcand_q <= 32'd0;
`else
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            vld_q   <= vld_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
`ifdef MDU_MUL_EN
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
`else
            ill_q   <= ill_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = vld_q;
    assign out_result = res_q;
    assign out_rd     = rd_q;
`ifdef MDU_MUL_EN
    assign out_illegal = 1'b0;
`else
    assign out_illegal = ill_q;
`endif

endmodule
